adc_frame_serializer: RTL

ADC_FRAME_SERIALIZER -- requirements
Module: adc_frame_serializer

---
 rtl/adc_frame_pkg.sv | 38 +++
 rtl/adc_frame_serializer_if.sv | 14 +
 rtl/sample_pair_fifo.sv | 55 +++++
 rtl/adc_frame_serializer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame serializer.
//   HDR_DATA / HDR_EMPTY : frame header bytes
//   CRC_POLY             : CRC-8 polynomial (used only with FRAME_CRC_EN)
//   ST_* / state_t       : frame FSM encodings and state type
// Optional feature macro: FRAME_CRC_EN (adds the CRC state and helper).
package adc_frame_pkg;

  localparam logic [7:0] HDR_DATA  = 8'hA5;
  localparam logic [7:0] HDR_EMPTY = 8'h3C;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

`ifdef FRAME_CRC_EN
  localparam logic [1:0] ST_CRC     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    HEADER  = ST_HEADER,
    PAYLOAD = ST_PAYLOAD,
    CRC     = ST_CRC
  } state_t;

  // One MSB-first CRC-8 step, init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC_POLY : 8'h00);
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    HEADER  = ST_HEADER,
    PAYLOAD = ST_PAYLOAD
  } state_t;
`endif

endpackage

// File: rtl/adc_frame_serializer_if.sv
// Sample bus carrying one decimated channel pair per strobe.
//   sample_a, sample_b : channel samples, unsigned, WIDTH bits
//   sample_valid       : one-cycle strobe qualifying the pair
// Modports: master drives the bus (ADC side), slave receives it (serializer).
interface adc_frame_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sample_a;
  logic [WIDTH-1:0] sample_b;
  logic             sample_valid;

  modport master (output sample_a, sample_b, sample_valid);
  modport slave  (input  sample_a, sample_b, sample_valid);
endinterface

// File: rtl/sample_pair_fifo.sv
// Small synchronous FIFO holding {A, B} sample pairs.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and data; accepted when not full or
//                     when a pop happens in the same cycle
//   pop, pop_data   : read request (ignored when empty), head-of-queue data
//   full, empty, count : occupancy, count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/adc_frame_serializer.sv
// Serializes buffered ADC sample pairs into framed bit streams on request.
//   clk, rst_n  : clock, asynchronous active-low reset (aborts any frame)
//   smp         : sample bus (slave), pushes {A, B} pairs into the FIFO
//   trigger     : asynchronous frame request pin, rising edge requests
//   serial_out  : frame bits MSB first, 0 when idle
//   frame_sync  : high during the first header bit only
//   busy        : high for every frame bit
//   overflow    : sticky, a pushed pair was dropped (cleared by reset only)
// Frame: header (A5 data / 3C empty), A, B, A-B [, CRC-8 if FRAME_CRC_EN].
module adc_frame_serializer
  import adc_frame_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adc_frame_serializer_if.slave   smp,
  input  logic                    trigger,
  output logic                    serial_out,
  output logic                    frame_sync,
  output logic                    busy,
  output logic                    overflow
);
  localparam int DATA_LEN = 8 + 3 * WIDTH;
`ifdef FRAME_CRC_EN
  localparam int FRAME_LEN = DATA_LEN + 8;
`else
  localparam int FRAME_LEN = DATA_LEN;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] HDR_LEN_C   = CW'(8);
  localparam logic [CW-1:0] DATA_LEN_C  = CW'(DATA_LEN);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

  logic trig_s1, trig_s2, trig_s3, req_q;
  state_t state;
  logic [CW-1:0] bitcnt;
  logic [DATA_LEN-1:0] shreg;
  logic [DATA_LEN-1:0] frame_load;
  logic start, pop;
  logic [2*WIDTH-1:0] pop_data;
  logic [WIDTH-1:0] pa, pb, pd;
  logic fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef FRAME_CRC_EN
  logic [7:0] crc;
`endif

  // trig_s3 only serves edge detection; req_q adds one stage so the first
  // header bit lands three edges after trigger is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {trig_s3, trig_s2, trig_s1} <= '0;
      req_q <= 1'b0;
    end else begin
      {trig_s3, trig_s2, trig_s1} <= {trig_s2, trig_s1, trigger};
      req_q <= trig_s2 & ~trig_s3;
    end
  end

  assign start = (state == IDLE) && req_q;
  assign pop   = start && !fifo_empty;

  sample_pair_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (smp.sample_valid),
    .push_data ({smp.sample_a, smp.sample_b}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {pa, pb} = pop_data;
  assign pd = pa - pb;

  always_comb begin
    frame_load = {HDR_DATA, pa, pb, pd};
    if (fifo_count == '0) frame_load = {HDR_EMPTY, {3 * WIDTH{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (smp.sample_valid && fifo_full && !pop) overflow <= 1'b1;
  end

  // Bit 0 is emitted on the start edge straight from frame_load; bitcnt then
  // holds the index of the bit emitted on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      serial_out <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
`ifdef FRAME_CRC_EN
      crc        <= '0;
`endif
    end else if (start) begin
      state      <= HEADER;
      bitcnt     <= CW'(1);
      shreg      <= {frame_load[DATA_LEN-2:0], 1'b0};
      serial_out <= frame_load[DATA_LEN-1];
      frame_sync <= 1'b1;
      busy       <= 1'b1;
`ifdef FRAME_CRC_EN
      crc        <= crc8_step(8'h00, frame_load[DATA_LEN-1]);
`endif
    end else if (state != IDLE) begin
      frame_sync <= 1'b0;
      if (bitcnt == FRAME_LEN_C) begin
        state      <= IDLE;
        busy       <= 1'b0;
        serial_out <= 1'b0;
      end else begin
        bitcnt <= bitcnt + 1'b1;
`ifdef FRAME_CRC_EN
        if (bitcnt >= DATA_LEN_C) begin
          state      <= CRC;
          serial_out <= crc[7];
          crc        <= {crc[6:0], 1'b0};
        end else
`endif
        begin
          if (bitcnt < HDR_LEN_C) state <= HEADER;
          else                    state <= PAYLOAD;
          serial_out <= shreg[DATA_LEN-1];
          shreg      <= {shreg[DATA_LEN-2:0], 1'b0};
`ifdef FRAME_CRC_EN
          crc        <= crc8_step(crc, shreg[DATA_LEN-1]);
`endif
        end
      end
    end
  end
endmodule
